dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 145 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: port 0 (pipeline memory stage) and port 1 (debug/DMA) share one memory.
// Build option: define DMEM_ARB_FIXED_PRIO_EN for fixed port-0 priority; round-robin otherwise.

package dmem_arbiter_pkg;
  typedef enum logic {
    MEM_READ_EN  = 1'b0,
    MEM_WRITE_EN = 1'b1
  } mem_en_t;

  typedef struct packed {
    logic        mem_enable;
    mem_en_t     mem_en;
    logic [31:0] address;
    logic [31:0] data_in;
  } data_memory_interface_t;
endpackage

module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req0,
  input  logic                   req1,
  input  logic                   we0,
  input  logic                   we1,
  input  logic [31:0]            addr0,
  input  logic [31:0]            addr1,
  input  logic [31:0]            wdata0,
  input  logic [31:0]            wdata1,
  output logic                   done0,
  output logic                   done1,
  output logic [31:0]            rdata,
  output logic                   stall0,
  output data_memory_interface_t mem_sig,
  input  logic [31:0]            mem_data_out
);

  localparam int         DATA_W    = 32;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ISSUE  = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;
  localparam bit         HAS_WAIT  = (WAIT_CYCLES != 0);
  localparam logic [3:0] WAIT_LAST = HAS_WAIT ? 4'(WAIT_CYCLES - 1) : 4'd0;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [3:0]        wait_cnt;
  logic              grant;
  logic              grant_port;
  logic              owner_p0;
  logic              we_p0;
  logic [DATA_W-1:0] addr_p0;
  logic [DATA_W-1:0] wdata_p0;
  logic              issue;
  logic              done_st;

  assign grant = (state == ST_IDLE) && (req0 || req1);

`ifdef DMEM_ARB_FIXED_PRIO_EN
  always_comb begin
    grant_port = ~req0;
  end
`else
  logic last_owner;

  // On contention the port that did not own the previous access wins.
  always_comb begin
    if (req0 && req1) grant_port = ~last_owner;
    else              grant_port = ~req0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     last_owner <= 1'b1;
    else if (grant) last_owner <= grant_port;
  end
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (req0 || req1) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = HAS_WAIT ? ST_WAIT : ST_DONE;
      ST_WAIT:  if (wait_cnt == WAIT_LAST) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Counter is cleared while leaving ISSUE so WAIT always starts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 wait_cnt <= 4'd0;
    else if (state == ST_ISSUE) wait_cnt <= 4'd0;
    else if (state == ST_WAIT)  wait_cnt <= sat_inc4(wait_cnt);
  end

  // Request capture stage: the winner's fields are frozen for the whole access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_p0 <= 1'b0;
      we_p0    <= 1'b0;
      addr_p0  <= '0;
      wdata_p0 <= '0;
    end else if (grant) begin
      owner_p0 <= grant_port;
      we_p0    <= grant_port ? we1    : we0;
      addr_p0  <= grant_port ? addr1  : addr0;
      wdata_p0 <= grant_port ? wdata1 : wdata0;
    end
  end

  // Memory-side and requester-side outputs decode directly from state.
  assign issue   = (state == ST_ISSUE);
  assign done_st = (state == ST_DONE);

  always_comb begin
    mem_sig.mem_enable = issue;
    mem_sig.mem_en     = (issue && we_p0) ? MEM_WRITE_EN : MEM_READ_EN;
    mem_sig.address    = addr_p0;
    mem_sig.data_in    = (issue && we_p0) ? wdata_p0 : '0;
  end

  assign done0  = done_st & ~owner_p0;
  assign done1  = done_st &  owner_p0;
  assign rdata  = (done_st && !we_p0) ? mem_data_out : '0;
  assign stall0 = req0 & ~done0;

  a_done_excl : assert property (@(posedge clk) disable iff (!rst_n) !(done0 && done1));
  a_issue_one : assert property (@(posedge clk) disable iff (!rst_n) issue |=> !issue);
  a_wait_bnd  : assert property (@(posedge clk) disable iff (!rst_n)
                                 (state == ST_WAIT) |-> (wait_cnt <= WAIT_LAST));

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed accesses, contention, reset abort, wait-state latency.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  localparam int W = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  logic        req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        done0, done1, stall0;
  logic [31:0] rdata, mem_data_out;
  data_memory_interface_t mem_sig;

  dmem_arbiter #(.WAIT_CYCLES(W)) u_dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .done0(done0), .done1(done1), .rdata(rdata), .stall0(stall0),
    .mem_sig(mem_sig), .mem_data_out(mem_data_out)
  );

  // Second and third copies exercise the wait-state extremes.
  logic        req_a = 1'b0, req_b = 1'b0;
  logic        zero1 = 1'b0;
  logic [31:0] zero32 = 32'h0;
  logic [31:0] addr_lat = 32'h104;
  logic        done0_a, done1_a, stall0_a, done0_b, done1_b, stall0_b;
  logic [31:0] rdata_a, rdata_b, mdo_a, mdo_b;
  data_memory_interface_t sig_a, sig_b;

  dmem_arbiter #(.WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst_n(rst_n), .req0(req_a), .req1(zero1), .we0(zero1), .we1(zero1),
    .addr0(addr_lat), .addr1(zero32), .wdata0(zero32), .wdata1(zero32),
    .done0(done0_a), .done1(done1_a), .rdata(rdata_a), .stall0(stall0_a),
    .mem_sig(sig_a), .mem_data_out(mdo_a)
  );

  dmem_arbiter #(.WAIT_CYCLES(15)) u_w15 (
    .clk(clk), .rst_n(rst_n), .req0(req_b), .req1(zero1), .we0(zero1), .we1(zero1),
    .addr0(addr_lat), .addr1(zero32), .wdata0(zero32), .wdata1(zero32),
    .done0(done0_b), .done1(done1_b), .rdata(rdata_b), .stall0(stall0_b),
    .mem_sig(sig_b), .mem_data_out(mdo_b)
  );

  int errors = 0;
  int checks = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string obs, input string req);
    checks++;
    errors++;
    $display("FAIL %s: observed %s, required %s", name, obs, req);
  endtask

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    case (a)
      32'h100: return 32'hDEADBEEF;
      32'h104: return 32'hCAFEF00D;
      32'h200: return 32'h13579BDF;
      default: return 32'h0BADC0DE;
    endcase
  endfunction

  // Memory models: read data is valid only WAIT+1 cycles after the enable cycle.
  int          en_cyc = -100, en_cyc_a = -100, en_cyc_b = -100;
  logic [31:0] en_addr = 0, en_addr_a = 0, en_addr_b = 0;

  initial forever begin
    @(negedge clk);
    if (mem_sig.mem_enable && mem_sig.mem_en == MEM_READ_EN) begin
      en_cyc = cyc; en_addr = mem_sig.address;
    end
    if (sig_a.mem_enable && sig_a.mem_en == MEM_READ_EN) begin
      en_cyc_a = cyc; en_addr_a = sig_a.address;
    end
    if (sig_b.mem_enable && sig_b.mem_en == MEM_READ_EN) begin
      en_cyc_b = cyc; en_addr_b = sig_b.address;
    end
  end

  assign mem_data_out = (cyc == en_cyc + W + 1)    ? mem_val(en_addr)   : 32'hBAD0BAD0;
  assign mdo_a        = (cyc == en_cyc_a + 0 + 1)  ? mem_val(en_addr_a) : 32'hBAD0BAD0;
  assign mdo_b        = (cyc == en_cyc_b + 15 + 1) ? mem_val(en_addr_b) : 32'hBAD0BAD0;

  typedef struct { logic we; logic [31:0] addr; logic [31:0] data; int cyc; } iss_t;
  typedef struct { logic port; logic [31:0] rdata; int cyc; } done_t;
  iss_t  iss_q[$];
  done_t done_q[$];

  // Monitor: pops expectations whenever the DUT issues to memory or completes.
  initial forever begin
    iss_t  ie;
    done_t de;
    @(negedge clk);
    if (rst_n) begin
      check1("done_excl", done0 & done1, 1'b0);
      if (mem_sig.mem_enable) begin
        if (iss_q.size() == 0) fail_now("unexp_issue", "mem_enable=1", "no issue");
        else begin
          ie = iss_q.pop_front();
          check1("iss_mem_en", mem_sig.mem_en, ie.we ? MEM_WRITE_EN : MEM_READ_EN);
          check32("iss_addr", mem_sig.address, ie.addr);
          check32("iss_data_in", mem_sig.data_in, ie.data);
          check32("iss_cycle", cyc, ie.cyc);
        end
      end else begin
        check1("idle_mem_en", mem_sig.mem_en, MEM_READ_EN);
        check32("idle_data_in", mem_sig.data_in, 32'h0);
      end
      if (done0 || done1) begin
        if (done_q.size() == 0) fail_now("unexp_done", "done pulse", "no done");
        else begin
          de = done_q.pop_front();
          check1("done_port", done1, de.port);
          check32("done_rdata", rdata, de.rdata);
          check32("done_cycle", cyc, de.cyc);
        end
      end else begin
        check32("rdata_idle", rdata, 32'h0);
      end
    end
  end

  task automatic access(input logic port, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata,
                        input bit scramble);
    int g;
    bit seen;
    g = cyc;
    iss_q.push_back('{we, addr, we ? wdata : 32'h0, g + 1});
    done_q.push_back('{port, exp_rdata, g + 2 + W});
    if (!port) begin req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata; end
    else       begin req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata; end
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (scramble && cyc == g + 2) begin
        addr0 = 32'hFFFF_FFF0;
        #1 check32("addr_hold_in_wait", mem_sig.address, addr);
      end
      if (port ? done1 : done0) begin
        seen = 1'b1;
        if (!port) check1("stall0_at_done", stall0, 1'b0);
      end else if (!port) begin
        check1("stall0_busy", stall0, 1'b1);
      end
    end
    if (!seen) begin
      fail_now("done_timeout", "no done in 40 cycles", "done pulse");
      iss_q.delete();
      done_q.delete();
    end
    @(posedge clk); #1;
    if (!port) req0 = 1'b0; else req1 = 1'b0;
  endtask

  initial begin
    #100000;
    fail_now("watchdog", "time limit reached", "finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int  c;
    bit  sa, sb;
    logic p;
    req0 = 1'b1; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = 32'h55; addr1 = 32'h0; wdata0 = 32'h99; wdata1 = 32'h0;
    repeat (2) @(negedge clk);
    check1("rst_mem_enable", mem_sig.mem_enable, 1'b0);
    check1("rst_mem_en", mem_sig.mem_en, MEM_READ_EN);
    check32("rst_address", mem_sig.address, 32'h0);
    check32("rst_data_in", mem_sig.data_in, 32'h0);
    check1("rst_done0", done0, 1'b0);
    check1("rst_done1", done1, 1'b0);
    check32("rst_rdata", rdata, 32'h0);
    check1("rst_stall0", stall0, 1'b1);
    req0 = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;

    access(1'b0, 1'b0, 32'h100, 32'h0,        32'hDEADBEEF, 1'b0);
    access(1'b1, 1'b1, 32'h20,  32'h1234,     32'h0,        1'b0);
    access(1'b0, 1'b1, 32'h44,  32'hA5A55A5A, 32'h0,        1'b0);
    access(1'b1, 1'b0, 32'h104, 32'hFFFFFFFF, 32'hCAFEF00D, 1'b0);
    access(1'b0, 1'b0, 32'h200, 32'h77,       32'h13579BDF, 1'b1);
    access(1'b0, 1'b0, 32'h300, 32'h0,        32'h0BADC0DE, 1'b0);

    // Contention from reset, both ports loading and holding req.
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    c = cyc;
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h100; wdata0 = 32'h0;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h200; wdata1 = 32'h0;
    for (int k = 0; k < 4; k++) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
      p = 1'b0;
`else
      p = (k % 2) == 1;
`endif
      iss_q.push_back('{1'b0, p ? 32'h200 : 32'h100, 32'h0, c + 1 + 4 * k});
      done_q.push_back('{p, p ? 32'h13579BDF : 32'hDEADBEEF, c + 3 + 4 * k});
    end
    repeat (16) @(negedge clk);
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;
    check32("contention_done_left", done_q.size(), 32'h0);

    // Reset during WAIT of a load aborts it.
    c = cyc;
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h100;
    iss_q.push_back('{1'b0, 32'h100, 32'h0, c + 1});
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check1("abort_mem_enable", mem_sig.mem_enable, 1'b0);
    check32("abort_address", mem_sig.address, 32'h0);
    check1("abort_done0", done0, 1'b0);
    check32("abort_rdata", rdata, 32'h0);
    req0 = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check1("no_done_after_rst", done0, 1'b0);
    end
    @(posedge clk); #1;
    access(1'b0, 1'b0, 32'h104, 32'h0, 32'hCAFEF00D, 1'b0);

    // Wait-state extremes: latency 2 and 17 from the grant cycle.
    c = cyc;
    sa = 1'b0; sb = 1'b0;
    req_a = 1'b1; req_b = 1'b1;
    fork
      begin
        for (int i = 0; i < 30 && !sa; i++) begin
          @(negedge clk);
          check1("w0_done1_low", done1_a, 1'b0);
          if (done0_a) begin
            sa = 1'b1;
            check32("w0_latency", cyc - c, 32'd2);
            check32("w0_rdata", rdata_a, 32'hCAFEF00D);
          end
        end
        if (!sa) fail_now("w0_timeout", "no done0", "done0 at grant+2");
        @(posedge clk); #1 req_a = 1'b0;
      end
      begin
        for (int j = 0; j < 30 && !sb; j++) begin
          @(negedge clk);
          check1("w15_done1_low", done1_b, 1'b0);
          if (done0_b) begin
            sb = 1'b1;
            check32("w15_latency", cyc - c, 32'd17);
            check32("w15_rdata", rdata_b, 32'hCAFEF00D);
          end
        end
        if (!sb) fail_now("w15_timeout", "no done0", "done0 at grant+17");
        @(posedge clk); #1 req_b = 1'b0;
      end
    join
    repeat (3) @(negedge clk);
    check1("w0_stall0_idle", stall0_a, 1'b0);
    check1("w15_stall0_idle", stall0_b, 1'b0);
    check1("w0_mem_idle", sig_a.mem_enable, 1'b0);
    check1("w15_mem_idle", sig_b.mem_enable, 1'b0);
    check32("iss_q_left", iss_q.size(), 32'h0);
    check32("done_q_left", done_q.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
